// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the MIPS E stage.
// Results are computed when the op is accepted and committed to HI/LO when the busy window ends.
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             start,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             req_drop
);
   localparam int CMAX = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic             zero_div_q, zero_div_d, drop_q, drop_d;
   logic             is_mul, is_div, a_neg, b_neg, m_sgn;
   logic [WIDTH-1:0] a_mag, b_mag, quo, rem;
   logic [2*WIDTH-1:0] prod;

   // Signed divide works on magnitudes; MIN_INT/-1 wraps back to MIN_INT naturally.
   always_comb begin
      is_mul = md_op == 3'd1 || md_op == 3'd2;
      is_div = md_op == 3'd3 || md_op == 3'd4;
      m_sgn  = md_op == 3'd1;
      a_neg  = md_op == 3'd3 && a[WIDTH-1];
      b_neg  = md_op == 3'd3 && b[WIDTH-1];
      prod   = {{WIDTH{m_sgn && a[WIDTH-1]}}, a} * {{WIDTH{m_sgn && b[WIDTH-1]}}, b};
      a_mag  = a_neg ? -a : a;
      b_mag  = b == '0 ? WIDTH'(1) : b_neg ? -b : b;
      quo    = (a_neg ^ b_neg) ? -(a_mag / b_mag) : a_mag / b_mag;
      rem    = a_neg ? -(a_mag % b_mag) : a_mag % b_mag;
   end

   assign busy     = state_q == RUN;
   assign start    = req && !busy && (is_mul || is_div);
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign req_drop = drop_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      pend_hi_d  = pend_hi_q;
      pend_lo_d  = pend_lo_q;
      zero_div_d = zero_div_q;
      drop_d     = req && busy && md_op != 3'd0 && md_op != 3'd7;
      if (state_q == IDLE) begin
         if (start) begin
            state_d                = RUN;
            cnt_d                  = is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
            {pend_hi_d, pend_lo_d} = is_mul ? prod : {rem, quo};
            zero_div_d             = is_div && b == '0;
         end
         hi_d = req && md_op == 3'd5 ? a : hi_q;
         lo_d = req && md_op == 3'd6 ? a : lo_q;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         state_d = IDLE;
         hi_d    = zero_div_q ? hi_q : pend_hi_q;
         lo_d    = zero_div_q ? lo_q : pend_lo_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         pend_hi_q  <= '0;
         pend_lo_q  <= '0;
         zero_div_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         pend_hi_q  <= pend_hi_d;
         pend_lo_q  <= pend_lo_d;
         zero_div_q <= zero_div_d;
         drop_q     <= drop_d;
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: drives a default md_unit and a single-cycle-latency md_unit from one stimulus
// stream and checks both against a transaction-level model of HI/LO and the busy window.
module tb_md_unit;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] a = '0, b = '0;
   logic        st_w[2], bz_w[2], dr_w[2];
   logic [31:0] hi_w[2], lo_w[2];
   int          total = 0, bad = 0;

   logic [31:0] m_hi[2], m_lo[2], m_phi[2], m_plo[2];
   int          m_rem[2];
   bit          m_zd[2], m_drop[2];
   logic [63:0] res_c;

   always #5 clk = ~clk;

   md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
      .clk(clk), .reset_n(reset_n), .req(req), .md_op(md_op), .a(a), .b(b),
      .start(st_w[0]), .busy(bz_w[0]), .hi(hi_w[0]), .lo(lo_w[0]), .req_drop(dr_w[0]));

   md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .req(req), .md_op(md_op), .a(a), .b(b),
      .start(st_w[1]), .busy(bz_w[1]), .hi(hi_w[1]), .lo(lo_w[1]), .req_drop(dr_w[1]));

   function automatic logic [63:0] md_res(logic [2:0] op, logic [31:0] x, logic [31:0] y);
      longint sx, sy;
      longint unsigned ux, uy;
      sx = $signed(x);
      sy = $signed(y);
      ux = x;
      uy = y;
      case (op)
         3'd1: return sx * sy;
         3'd2: return ux * uy;
         3'd3: return y == 0 ? 64'd0 : {32'(sx % sy), 32'(sx / sy)};
         3'd4: return y == 0 ? 64'd0 : {32'(ux % uy), 32'(ux / uy)};
         default: return 64'd0;
      endcase
   endfunction

   function automatic int lat(int k, logic [2:0] op);
      return k == 1 ? 1 : (op <= 3'd2 ? 5 : 10);
   endfunction

   always_comb res_c = md_res(md_op, a, b);

   // Model: m_rem counts the busy cycles still to go; results commit as it reaches zero.
   always @(posedge clk or negedge reset_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset_n) begin
            m_hi[k] <= '0; m_lo[k] <= '0; m_phi[k] <= '0; m_plo[k] <= '0;
            m_rem[k] <= 0; m_zd[k] <= 1'b0; m_drop[k] <= 1'b0;
         end else begin
            m_drop[k] <= req && m_rem[k] > 0 && md_op != 3'd0 && md_op != 3'd7;
            if (m_rem[k] > 0) begin
               m_rem[k] <= m_rem[k] - 1;
               if (m_rem[k] == 1 && !m_zd[k]) begin
                  m_hi[k] <= m_phi[k];
                  m_lo[k] <= m_plo[k];
               end
            end else if (req && md_op >= 3'd1 && md_op <= 3'd4) begin
               m_rem[k] <= lat(k, md_op);
               m_phi[k] <= res_c[63:32];
               m_plo[k] <= res_c[31:0];
               m_zd[k]  <= md_op >= 3'd3 && b == 0;
            end else if (req && md_op == 3'd5) begin
               m_hi[k] <= a;
            end else if (req && md_op == 3'd6) begin
               m_lo[k] <= a;
            end
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("busy%0d", k), 32'(bz_w[k]), 32'(m_rem[k] > 0));
         chk($sformatf("start%0d", k), 32'(st_w[k]),
             32'(req && m_rem[k] == 0 && md_op >= 3'd1 && md_op <= 3'd4));
         chk($sformatf("drop%0d", k), 32'(dr_w[k]), 32'(m_drop[k]));
         chk($sformatf("hi%0d", k), hi_w[k], m_hi[k]);
         chk($sformatf("lo%0d", k), lo_w[k], m_lo[k]);
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit r, logic [2:0] op, logic [31:0] x, logic [31:0] y);
      req = r; md_op = op; a = x; b = y;
   endtask

   task automatic wait_idle;
      int n = 0;
      while (bz_w[0] && n < 40) begin
         step();
         n++;
      end
      chk("idle_timeout", 32'(n), 32'(n < 40 ? n : 0));
   endtask

   logic [31:0] rv[6];

   initial begin
      rv[0] = 32'h0; rv[1] = 32'hFFFFFFFF; rv[2] = 32'h80000000;
      rv[3] = 32'h7FFFFFFF; rv[4] = 32'd1; rv[5] = 32'd7;
      step(); step();
      chk("rst_busy", 32'(bz_w[0]), 0);
      chk("rst_hi", hi_w[0], 0);
      chk("rst_lo", lo_w[0], 0);
      chk("rst_drop", 32'(dr_w[0]), 0);
      reset_n = 1'b1;
      step();
      // MULT -3*7: busy for exactly five cycles
      drive(1, 3'd1, 32'hFFFFFFFD, 32'd7);
      step();
      drive(0, 3'd0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("t1_busy", 32'(bz_w[0]), 1);
         step();
      end
      chk("t1_busy_fall", 32'(bz_w[0]), 0);
      chk("t1_hi", hi_w[0], 32'hFFFFFFFF);
      chk("t1_lo", lo_w[0], 32'hFFFFFFEB);
      drive(1, 3'd2, 32'hFFFFFFFF, 32'd2);
      step();
      drive(0, 3'd0, 0, 0);
      wait_idle();
      chk("t2_hi", hi_w[0], 32'd1);
      chk("t2_lo", lo_w[0], 32'hFFFFFFFE);
      drive(1, 3'd3, 32'hFFFFFFF9, 32'd2);
      step();
      drive(0, 3'd0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         chk("t2_div_busy", 32'(bz_w[0]), 1);
         step();
      end
      chk("t2_div_fall", 32'(bz_w[0]), 0);
      chk("t2_div_lo", lo_w[0], 32'hFFFFFFFD);
      chk("t2_div_hi", hi_w[0], 32'hFFFFFFFF);
      drive(1, 3'd5, 32'h11, 0); step();
      drive(1, 3'd6, 32'h22, 0); step();
      drive(1, 3'd4, 32'd7, 32'd0); step();
      drive(0, 3'd0, 0, 0);
      chk("t3_busy", 32'(bz_w[0]), 1);
      wait_idle();
      chk("t3_hi", hi_w[0], 32'h11);
      chk("t3_lo", lo_w[0], 32'h22);
      drive(1, 3'd3, 32'h80000000, 32'hFFFFFFFF); step();
      drive(0, 3'd0, 0, 0);
      wait_idle();
      chk("t3_min_lo", lo_w[0], 32'h80000000);
      chk("t3_min_hi", hi_w[0], 32'h0);
      drive(1, 3'd5, 32'hCAFE0000, 0); step();
      drive(0, 3'd0, 0, 0);
      chk("t4_hi", hi_w[0], 32'hCAFE0000);
      chk("t4_busy", 32'(bz_w[0]), 0);
      drive(1, 3'd1, 32'd1, 32'd1); step();
      drive(1, 3'd6, 32'h5555, 0); step();
      drive(0, 3'd0, 0, 0);
      chk("t4_drop", 32'(dr_w[0]), 1);
      step();
      chk("t4_drop_once", 32'(dr_w[0]), 0);
      wait_idle();
      chk("t4_lo", lo_w[0], 32'd1);
      drive(1, 3'd3, 32'd100, 32'd3); step();
      drive(0, 3'd0, 0, 0);
      step(); step();
      #2 reset_n = 1'b0;
      #1;
      chk("t5_busy", 32'(bz_w[0]), 0);
      chk("t5_hi", hi_w[0], 0);
      chk("t5_lo", lo_w[0], 0);
      step();
      reset_n = 1'b1;
      drive(1, 3'd1, 32'd3, 32'd5);
      #1 chk("t5_start", 32'(st_w[0]), 1);
      step();
      drive(0, 3'd0, 0, 0);
      chk("t5_accept", 32'(bz_w[0]), 1);
      wait_idle();
      chk("t5_lo_res", lo_w[0], 32'd15);
      drive(1, 3'd1, 32'd2, 32'd3); step();
      drive(1, 3'd1, 32'd4, 32'd5);
      chk("t6_busy", 32'(bz_w[1]), 1);
      chk("t6_start_blk", 32'(st_w[1]), 0);
      step();
      chk("t6_fall", 32'(bz_w[1]), 0);
      chk("t6_lo1", lo_w[1], 32'd6);
      chk("t6_start", 32'(st_w[1]), 1);
      step();
      drive(0, 3'd0, 0, 0);
      chk("t6_busy2", 32'(bz_w[1]), 1);
      step();
      chk("t6_lo2", lo_w[1], 32'd20);
      wait_idle();
      for (int i = 0; i < 3000; i++) begin
         reset_n = $urandom_range(0, 399) != 0;
         drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
               $urandom_range(0, 3) == 0 ? rv[$urandom_range(0, 5)] : $urandom,
               $urandom_range(0, 3) == 0 ? rv[$urandom_range(0, 5)] : $urandom);
         step();
      end
      reset_n = 1'b1;
      drive(0, 3'd0, 0, 0);
      step(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
